// File: rtl/median_feeder.sv
// Feeder for the 9-pixel median core: buffers a 3x3 window, streams it on DI/DSI,
// waits for DSO and hands the median downstream. Optional WAIT timeout: MEDIAN_FEEDER_TIMEOUT_EN.
module median_feeder #(
    parameter int SIZE    = 8,
    parameter int NPIX    = 9,
    parameter int TIMEOUT = 63
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [SIZE-1:0] PIX_IN,
    input  logic            PIX_VALID,
    output logic            PIX_READY,
    output logic [SIZE-1:0] DI,
    output logic            DSI,
    input  logic [SIZE-1:0] DO,
    input  logic            DSO,
    output logic [SIZE-1:0] RES,
    output logic            RES_VALID,
    input  logic            RES_READY,
    output logic            BUSY
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    ,
    output logic            ERR
`endif
);

    typedef enum logic [1:0] {S_LOAD, S_SEND, S_WAIT, S_RESULT} state_t;

    localparam logic [3:0] LAST = 4'(NPIX - 1);

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d, cnt_nxt;
    logic [NPIX-1:0][SIZE-1:0]  buf_q, buf_d;
    logic                       pix_ready_q, pix_ready_d;
    logic                       dsi_q, dsi_d;
    logic [SIZE-1:0]            di_q, di_d;
    logic [SIZE-1:0]            res_q, res_d;
    logic                       res_valid_q, res_valid_d;
    logic                       busy_q, busy_d;
    logic                       ign_q, ign_d;

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    assign cnt_nxt = cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        pix_ready_d = pix_ready_q;
        dsi_d       = dsi_q;
        di_d        = di_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        ign_d       = ign_q;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (PIX_VALID && pix_ready_q) begin
                    buf_d[cnt_q] = PIX_IN;
                    if (cnt_q == LAST) begin
                        // buf[0] is already stored, so the first DSI cycle follows the last accept directly
                        cnt_d       = 4'd0;
                        state_d     = S_SEND;
                        pix_ready_d = 1'b0;
                        dsi_d       = 1'b1;
                        di_d        = buf_q[0];
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            S_SEND: begin
                if (cnt_q == LAST) begin
                    cnt_d   = 4'd0;
                    dsi_d   = 1'b0;
                    di_d    = '0;
                    ign_d   = 1'b1;
                    state_d = S_WAIT;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_nxt;
                    di_d  = buf_q[cnt_nxt];
                end
            end
            S_WAIT: begin
                // DSO may still be asserted from the previous window during the first WAIT cycle
                ign_d = 1'b0;
                if (!ign_q && DSO) begin
                    res_d       = DO;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d       = 1'b1;
                    res_d       = '0;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end
                tmo_d = tmo_q + 1'b1;
`endif
            end
            S_RESULT: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    pix_ready_d = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        busy_d = !(state_d == S_LOAD && cnt_d == 4'd0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_LOAD;
            cnt_q       <= 4'd0;
            pix_ready_q <= 1'b1;
            dsi_q       <= 1'b0;
            di_q        <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ign_q       <= 1'b0;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            pix_ready_q <= pix_ready_d;
            dsi_q       <= dsi_d;
            di_q        <= di_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            ign_q       <= ign_d;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign PIX_READY = pix_ready_q;
    assign DSI       = dsi_q;
    assign DI        = di_q;
    assign RES       = res_q;
    assign RES_VALID = res_valid_q;
    assign BUSY      = busy_q;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    assign ERR       = err_q;
`endif

endmodule
